fetch_unit: RTL and testbench

- Instruction-fetch stage of the Hack CPU pipeline; sits directly upstream of instruction decode.
- Generates sequential PCs and issues read requests to instruction ROM; the ROM has variable latency and returns responses in order.
- Buffers returned instructions with their PCs in an in-order entry queue and presents them to decode as fetch_st {pc, inst} over a vld/gnt handshake.
- On invalidate (branch redirect from execute), flushes the queue, discards responses still in flight, and restarts fetch at redirect_pc.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Hack CPU instruction-fetch stage: sequential PC issue to a variable-latency in-order ROM,
// in-order entry queue to decode, flush/redirect on invalidate. Define FETCH_PROTERR_EN for proto_err.
module fetch_unit #(
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter int unsigned     PC_W       = 15,
  parameter int unsigned     INST_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rsp_vld,
  input  logic [INST_W-1:0]      imem_rsp_data,
  output logic [PC_W+INST_W-1:0] fetched_info,
  output logic                   fetched_vld,
  input  logic                   fetched_gnt,
  input  logic                   invalidate,
  input  logic [PC_W-1:0]        redirect_pc
`ifdef FETCH_PROTERR_EN
  ,
  output logic                   proto_err
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_st;

  logic [PC_W-1:0]       r_pc;
  logic [PC_W-1:0]       r_q_pc   [FIFO_DEPTH];
  logic [INST_W-1:0]     r_q_inst [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_q_filled;
  logic [AW-1:0]         r_alloc_ptr;
  logic [AW-1:0]         r_fill_ptr;
  logic [AW-1:0]         r_head_ptr;
  logic [CW-1:0]         r_alloc_cnt;
  logic [CW-1:0]         r_unfilled_cnt;
  logic [CW-1:0]         r_drop_cnt;

  logic [CW:0] w_inflight;
  logic        w_req;
  logic        w_acc;
  logic        w_drop;
  logic        w_fill;
  logic        w_spur;
  logic        w_rsp_used;
  logic        w_vld;
  logic        w_pop;
  fetch_st     w_head;

  // Allocated entries plus responses still owed to a flushed window bound the ROM backlog.
  assign w_inflight = {1'b0, r_alloc_cnt} + {1'b0, r_drop_cnt};
  assign w_req      = !rst && !invalidate && (w_inflight < DEPTH_C);
  assign w_acc      = w_req && imem_gnt;
  assign w_drop     = imem_rsp_vld && (r_drop_cnt != '0);
  assign w_spur     = imem_rsp_vld && (r_drop_cnt == '0) && (r_unfilled_cnt == '0);
  assign w_rsp_used = imem_rsp_vld && !w_spur;
  assign w_fill     = imem_rsp_vld && (r_drop_cnt == '0) && (r_unfilled_cnt != '0);
  assign w_vld      = r_q_filled[r_head_ptr];
  assign w_pop      = w_vld && fetched_gnt && !invalidate;

  assign w_head.pc   = r_q_pc[r_head_ptr];
  assign w_head.inst = r_q_inst[r_head_ptr];

  assign imem_req     = w_req;
  assign imem_addr    = r_pc;
  assign fetched_vld  = w_vld;
  assign fetched_info = w_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_q_filled     <= '0;
      r_alloc_ptr    <= '0;
      r_fill_ptr     <= '0;
      r_head_ptr     <= '0;
      r_alloc_cnt    <= '0;
      r_unfilled_cnt <= '0;
      r_drop_cnt     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_q_pc[i]   <= '0;
        r_q_inst[i] <= '0;
      end
    end else if (invalidate) begin
      // Every unfilled entry still has a response coming; the one arriving now is already spent.
      r_pc           <= redirect_pc;
      r_q_filled     <= '0;
      r_alloc_ptr    <= '0;
      r_fill_ptr     <= '0;
      r_head_ptr     <= '0;
      r_alloc_cnt    <= '0;
      r_unfilled_cnt <= '0;
      r_drop_cnt     <= r_drop_cnt + r_unfilled_cnt - CW'(w_rsp_used);
    end else begin
      if (w_acc) begin
        r_q_pc[r_alloc_ptr]     <= r_pc;
        r_q_filled[r_alloc_ptr] <= 1'b0;
        r_alloc_ptr             <= r_alloc_ptr + AW'(1);
        r_pc                    <= r_pc + PC_W'(1);
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
      if (w_fill) begin
        r_q_inst[r_fill_ptr]   <= imem_rsp_data;
        r_q_filled[r_fill_ptr] <= 1'b1;
        r_fill_ptr             <= r_fill_ptr + AW'(1);
      end
      if (w_pop) begin
        r_q_filled[r_head_ptr] <= 1'b0;
        r_head_ptr             <= r_head_ptr + AW'(1);
      end
      r_alloc_cnt    <= r_alloc_cnt + CW'(w_acc) - CW'(w_pop);
      r_unfilled_cnt <= r_unfilled_cnt + CW'(w_acc) - CW'(w_fill);
    end
  end

`ifdef FETCH_PROTERR_EN
  logic r_proto_err;

  // A response in the very cycle of the first accept also sees nothing owed, so w_spur covers it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_proto_err <= 1'b0;
    end else if (w_spur) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: ROM environment with in-order variable latency and a
// stream-level reference (expected issue/delivery PCs, backlog bound, head-valid rule).
module tb_fetch_unit;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 15;
  localparam int INST_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_gnt = 1'b0;
  logic              imem_rsp_vld = 1'b0;
  logic [INST_W-1:0] imem_rsp_data = '0;
  logic [30:0]       fetched_info;
  logic              fetched_vld;
  logic              fetched_gnt = 1'b0;
  logic              invalidate = 1'b0;
  logic [PC_W-1:0]   redirect_pc = '0;
`ifdef FETCH_PROTERR_EN
  logic              proto_err;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .FIFO_DEPTH(DEPTH),
    .PC_W(PC_W),
    .INST_W(INST_W),
    .RESET_PC(15'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rsp_vld(imem_rsp_vld),
    .imem_rsp_data(imem_rsp_data),
    .fetched_info(fetched_info),
    .fetched_vld(fetched_vld),
    .fetched_gnt(fetched_gnt),
    .invalidate(invalidate),
    .redirect_pc(redirect_pc)
`ifdef FETCH_PROTERR_EN
    ,
    .proto_err(proto_err)
`endif
  );

  typedef struct {
    logic [PC_W-1:0] addr;
    int              due;
    bit              stale;
  } rom_t;

  rom_t pend[$];
  int   cyc = 0;
  int   lat = 1;
  int   extra_max = 0;
  int   m_filled = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bit              o_req, o_acc, o_vld, o_pop, o_rsp, e_req, e_vld;
  logic [PC_W-1:0] o_addr;
  logic [30:0]     o_info;
  logic [PC_W-1:0] exp_pc, iss_pc;

  function automatic logic [15:0] rom(input logic [PC_W-1:0] a);
    return 16'(a) + 16'h0100;
  endfunction

  // One clock cycle: drive inputs at negedge, let the ROM answer, observe, update environment.
  task automatic step(input bit dg, input bit rg, input bit inv, input logic [PC_W-1:0] rpc,
                      input bit sp);
    rom_t r;
    bit   st;
    @(negedge clk);
    fetched_gnt = dg;
    imem_gnt    = rg;
    invalidate  = inv;
    redirect_pc = rpc;
    e_req = !inv && ((pend.size() + m_filled) < DEPTH);
    e_vld = (m_filled > 0);
    o_rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_vld  = o_rsp || sp;
    imem_rsp_data = o_rsp ? rom(pend[0].addr) : 16'($urandom);
    #1;
    o_req  = imem_req;
    o_addr = imem_addr;
    o_vld  = fetched_vld;
    o_info = fetched_info;
    o_acc  = o_req && rg;
    o_pop  = o_vld && dg && !inv;
    if (o_rsp) begin
      st = pend[0].stale || inv;
      void'(pend.pop_front());
      if (!st) m_filled++;
    end
    if (o_pop && m_filled > 0) m_filled--;
    if (o_acc) begin
      r.addr  = o_addr;
      r.due   = cyc + lat + ((extra_max > 0) ? $urandom_range(0, extra_max) : 0);
      r.stale = 1'b0;
      pend.push_back(r);
    end
    if (inv) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_filled = 0;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fetched_gnt = 1'b0; imem_gnt = 1'b0; invalidate = 1'b0; imem_rsp_vld = 1'b0;
    pend.delete();
    m_filled = 0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    lat = 2; extra_max = 0;
    repeat (6) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b exp 0", imem_req); end
    n_cmp++; if (fetched_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b exp 0", fetched_vld); end
    n_cmp++; if (fetched_info !== 31'h0) begin n_bad++; $display("FAIL reset_info: got %h exp 0", fetched_info); end
    n_cmp++; if (imem_addr !== 15'h0) begin n_bad++; $display("FAIL reset_addr: got %h exp 0", imem_addr); end
`ifdef FETCH_PROTERR_EN
    n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL reset_proterr: got %b exp 0", proto_err); end
`endif
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; extra_max = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      n_cmp++;
      if (o_req !== 1'b1 || o_addr !== 15'(k-1)) begin
        n_bad++; $display("FAIL stream_addr: cycle %0d got req=%b addr=%h exp req=1 addr=%h", k, o_req, o_addr, 15'(k-1));
      end
      n_cmp++;
      if (o_vld !== (k >= 3)) begin
        n_bad++; $display("FAIL stream_vld: cycle %0d got %b exp %b", k, o_vld, (k >= 3));
      end
      if (k >= 3) begin
        n_cmp++;
        if (o_info !== {15'(k-3), rom(15'(k-3))}) begin
          n_bad++; $display("FAIL stream_info: cycle %0d got %h exp %h", k, o_info, {15'(k-3), rom(15'(k-3))});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int pops = 0;
    do_reset();
    lat = 1; extra_max = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      if (o_acc) acc++;
      if (k >= 4) begin
        n_cmp++; if (o_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_full: cycle %0d got %b exp 0", k, o_req); end
      end
      if (o_vld) begin
        n_cmp++;
        if (o_info !== {15'h0, 16'h0100}) begin n_bad++; $display("FAIL bp_head_stable: got %h exp %h", o_info, {15'h0, 16'h0100}); end
      end
    end
    n_cmp++; if (acc != DEPTH) begin n_bad++; $display("FAIL bp_alloc: got %0d exp %0d", acc, DEPTH); end
    exp_pc = '0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      if (o_pop) begin
        pops++;
        n_cmp++;
        if (o_info !== {exp_pc, rom(exp_pc)}) begin n_bad++; $display("FAIL bp_drain: got %h exp %h", o_info, {exp_pc, rom(exp_pc)}); end
        exp_pc++;
      end
    end
    n_cmp++; if (pops != 12) begin n_bad++; $display("FAIL bp_drain_rate: got %0d exp 12", pops); end
  endtask

  task automatic test_invalidate();
    bit first_acc, first_pop;
    for (int sc = 0; sc < 2; sc++) begin
      do_reset();
      lat = 3; extra_max = 0;
      repeat (3) step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      if (sc == 0) begin
        step(1'b1, 1'b1, 1'b1, 15'h0040, 1'b0);
        exp_pc = 15'h0040;
      end else begin
        step(1'b1, 1'b1, 1'b1, 15'h0100, 1'b0);
        step(1'b1, 1'b1, 1'b1, 15'h0200, 1'b0);
        exp_pc = 15'h0200;
      end
      n_cmp++; if (o_req !== 1'b0) begin n_bad++; $display("FAIL inv_req: got %b exp 0", o_req); end
      iss_pc = exp_pc;
      first_acc = 1'b1; first_pop = 1'b1;
      for (int k = 0; k < 24; k++) begin
        step(1'b1, 1'b1, 1'b0, '0, 1'b0);
        if (k == 0) begin
          n_cmp++; if (o_vld !== 1'b0) begin n_bad++; $display("FAIL inv_vld_after: got %b exp 0", o_vld); end
        end
        n_cmp++; if (o_req !== e_req) begin n_bad++; $display("FAIL inv_req_bound: cycle %0d got %b exp %b", k, o_req, e_req); end
        if (o_acc) begin
          if (first_acc) begin
            n_cmp++; if (o_addr !== iss_pc) begin n_bad++; $display("FAIL inv_first_addr: got %h exp %h", o_addr, iss_pc); end
            first_acc = 1'b0;
          end
          iss_pc++;
        end
        if (o_pop) begin
          n_cmp++;
          if (o_info !== {exp_pc, rom(exp_pc)}) begin
            n_bad++; $display("FAIL inv_pop%s: got %h exp %h", first_pop ? "_first" : "", o_info, {exp_pc, rom(exp_pc)});
          end
          first_pop = 1'b0;
          exp_pc++;
        end
      end
      n_cmp++; if (first_pop) begin n_bad++; $display("FAIL inv_no_delivery: got 0 pops exp >0"); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 1; extra_max = 0;
    step(1'b1, 1'b1, 1'b1, 15'h7FFE, 1'b0);
    exp_pc = 15'h7FFE; iss_pc = 15'h7FFE;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      if (k < 3) begin
        n_cmp++;
        if (o_acc !== 1'b1 || o_addr !== iss_pc) begin n_bad++; $display("FAIL wrap_addr: cycle %0d got acc=%b addr=%h exp %h", k, o_acc, o_addr, iss_pc); end
      end
      if (o_acc) iss_pc++;
      if (o_pop) begin
        n_cmp++;
        if (o_info !== {exp_pc, rom(exp_pc)}) begin n_bad++; $display("FAIL wrap_pop: got %h exp %h", o_info, {exp_pc, rom(exp_pc)}); end
        exp_pc++;
      end
    end
    n_cmp++; if (exp_pc !== 15'h0004) begin n_bad++; $display("FAIL wrap_count: got next pc %h exp 0004", exp_pc); end
  endtask

  task automatic test_simultaneous();
    int acc = 0;
    int pops = 0;
    do_reset();
    lat = 1; extra_max = 0;
    repeat (3) begin
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      if (o_acc) acc++;
    end
    n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL simul_setup: got %0d exp 3", acc); end
    step(1'b1, 1'b1, 1'b0, '0, 1'b0);
    n_cmp++;
    if (!(o_acc && o_rsp && o_pop)) begin n_bad++; $display("FAIL simul_events: got acc=%b rsp=%b pop=%b exp 1 1 1", o_acc, o_rsp, o_pop); end
    n_cmp++;
    if (o_info !== {15'h0, rom(15'h0)}) begin n_bad++; $display("FAIL simul_head: got %h exp %h", o_info, {15'h0, rom(15'h0)}); end
    acc = 0;
    repeat (4) begin
      step(1'b0, 1'b1, 1'b0, '0, 1'b0);
      if (o_acc) acc++;
    end
    n_cmp++; if (acc != 1) begin n_bad++; $display("FAIL simul_alloc_kept: got %0d extra accepts exp 1", acc); end
    exp_pc = 15'h0001;
    repeat (10) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      if (o_pop) begin
        pops++;
        n_cmp++;
        if (o_info !== {exp_pc, rom(exp_pc)}) begin n_bad++; $display("FAIL simul_order: got %h exp %h", o_info, {exp_pc, rom(exp_pc)}); end
        exp_pc++;
      end
    end
    n_cmp++; if (pops != 4) begin n_bad++; $display("FAIL simul_pops: got %0d exp 4", pops); end
  endtask

  task automatic test_spurious();
    int pops = 0;
    do_reset();
    lat = 1; extra_max = 0;
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    repeat (3) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      n_cmp++; if (o_vld !== 1'b0) begin n_bad++; $display("FAIL spur_vld: got %b exp 0", o_vld); end
`ifdef FETCH_PROTERR_EN
      n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL spur_proterr: got %b exp 1", proto_err); end
`endif
    end
    exp_pc = '0;
    repeat (6) begin
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      if (o_pop) begin
        pops++;
        n_cmp++;
        if (o_info !== {exp_pc, rom(exp_pc)}) begin n_bad++; $display("FAIL spur_after: got %h exp %h", o_info, {exp_pc, rom(exp_pc)}); end
        exp_pc++;
      end
    end
    n_cmp++; if (pops != 4) begin n_bad++; $display("FAIL spur_pops: got %0d exp 4", pops); end
`ifdef FETCH_PROTERR_EN
    n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL spur_sticky: got %b exp 1", proto_err); end
    do_reset();
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL spur_first_accept: got %b exp 1", proto_err); end
`endif
  endtask

  task automatic test_random();
    bit              inv;
    logic [PC_W-1:0] rpc;
    do_reset();
    lat = 1 + $urandom_range(0, 2); extra_max = 3;
    exp_pc = '0; iss_pc = '0;
    for (int k = 0; k < 2000; k++) begin
      inv = ($urandom_range(0, 29) == 0);
      rpc = 15'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, inv, rpc, 1'b0);
      n_cmp++; if (o_req !== e_req) begin n_bad++; $display("FAIL rnd_req: cycle %0d got %b exp %b", k, o_req, e_req); end
      n_cmp++; if (o_vld !== e_vld) begin n_bad++; $display("FAIL rnd_vld: cycle %0d got %b exp %b", k, o_vld, e_vld); end
      if (o_acc) begin
        n_cmp++; if (o_addr !== iss_pc) begin n_bad++; $display("FAIL rnd_addr: cycle %0d got %h exp %h", k, o_addr, iss_pc); end
        iss_pc++;
      end
      if (o_pop) begin
        n_cmp++;
        if (o_info !== {exp_pc, rom(exp_pc)}) begin n_bad++; $display("FAIL rnd_pop: cycle %0d got %h exp %h", k, o_info, {exp_pc, rom(exp_pc)}); end
        exp_pc++;
      end
      if (inv) begin
        exp_pc = rpc;
        iss_pc = rpc;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_invalidate();
    test_wrap();
    test_simultaneous();
    test_spurious();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
